// File: rtl/shiftreg_mc.sv
// rtl/shiftreg_mc.sv - C-lane runtime-depth bit-serial shifter with parallel load; optional SHIFTREG_MC_ROTATE_EN adds rot input
module shiftreg_mc #(
  parameter int C = 1,
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [$clog2(N)-1:0]   len,
  input  logic                   load,
  input  logic [C*N-1:0]         pdata,
  input  logic                   step,
`ifdef SHIFTREG_MC_ROTATE_EN
  input  logic                   rot,
`endif
  input  logic [C-1:0]           in,
  output logic [C-1:0]           out,
  output logic [C*N-1:0]         pout,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = $clog2(N);

  logic [C-1:0][N-1:0] sr_q, sr_d;
  logic [LW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [LW-1:0]       tap;
  logic [C-1:0]        shin;

  // Output tap follows len; out-of-range len (only possible for non-power-of-2 N) is clamped
  if ((1 << LW) > N) begin : g_clamp
    assign tap = (len > LW'(N - 1)) ? LW'(N - 1) : len;
  end else begin : g_noclamp
    assign tap = len;
  end

  // Per-lane serial input: external bit, or the lane's own tap when rotating
  always_comb begin
    shin = '0;
    for (int c = 0; c < C; c++) begin
`ifdef SHIFTREG_MC_ROTATE_EN
      shin[c] = rot ? sr_q[c][tap] : in[c];
`else
      shin[c] = in[c];
`endif
    end
  end

  // Serial outputs read each lane at the tap position
  always_comb begin
    out = '0;
    for (int c = 0; c < C; c++) begin
      out[c] = sr_q[c][tap];
    end
  end

  assign pout = sr_q;
  assign busy = busy_q;
  assign done = done_q;

  // Next state: load beats step; counter only advances while a loaded word is in flight
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (load) begin
      sr_d   = pdata;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (step) begin
      for (int c = 0; c < C; c++) begin
        sr_d[c] = {sr_q[c][N-2:0], shin[c]};
      end
      if (busy_q) begin
        if (cnt_q == len) begin
          cnt_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_shiftreg_mc.sv
// tb/tb_shiftreg_mc.sv - scoreboard bench for shiftreg_mc with C=2, N=8
module tb_shiftreg_mc;

  localparam int C  = 2;
  localparam int N  = 8;
  localparam int LW = 3;

  localparam int K_OUT  = 0;
  localparam int K_BUSY = 1;
  localparam int K_DONE = 2;
  localparam int K_POUT = 3;
  localparam int K_NIB0 = 4;

  logic            clk = 1'b0;
  logic            clr;
  logic [LW-1:0]   len;
  logic            load;
  logic [C*N-1:0]  pdata;
  logic            step;
  logic [C-1:0]    in_s;
  logic [C-1:0]    out_s;
  logic [C*N-1:0]  pout;
  logic            busy;
  logic            done;
`ifdef SHIFTREG_MC_ROTATE_EN
  logic            rot;
`endif

  always #5 clk = ~clk;

  shiftreg_mc #(.C(C), .N(N)) dut (
    .clk   (clk),
    .clr   (clr),
    .len   (len),
    .load  (load),
    .pdata (pdata),
    .step  (step),
`ifdef SHIFTREG_MC_ROTATE_EN
    .rot   (rot),
`endif
    .in    (in_s),
    .out   (out_s),
    .pout  (pout),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string tag, input int kind, input logic [15:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic check_all();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [15:0] obs;
      e = sb.pop_front();
      case (e.kind)
        K_OUT:   obs = {14'd0, out_s};
        K_BUSY:  obs = {15'd0, busy};
        K_DONE:  obs = {15'd0, done};
        K_POUT:  obs = pout;
        default: obs = {12'd0, pout[3:0]};
      endcase
      tests++;
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s kind=%0d observed=%0h expected=%0h", e.tag, e.kind, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Load a word, shift it out with len+1 steps, checking every out bit (MSB of window first) and done timing
  task automatic run_word(input string tag, input logic [15:0] pd, input int l);
    len   = LW'(l);
    pdata = pd;
    load  = 1'b1;
    tick();
    load = 1'b0;
    push({tag, "_pout"}, K_POUT, pd);
    push({tag, "_busy0"}, K_BUSY, 16'd1);
    push({tag, "_done0"}, K_DONE, 16'd0);
    check_all();
    for (int k = 0; k <= l; k++) begin
      push($sformatf("%s_out%0d", tag, k), K_OUT, {14'd0, pd[8 + l - k], pd[l - k]});
      check_all();
      do_step();
      push($sformatf("%s_done_s%0d", tag, k + 1), K_DONE, {15'd0, (k == l)});
      push($sformatf("%s_busy_s%0d", tag, k + 1), K_BUSY, {15'd0, (k != l)});
      check_all();
    end
    tick();
    push({tag, "_done_idle"}, K_DONE, 16'd0);
    check_all();
  endtask

  initial begin
    clr   = 1'b0;
    len   = '0;
    load  = 1'b0;
    pdata = '0;
    step  = 1'b0;
    in_s  = '0;
`ifdef SHIFTREG_MC_ROTATE_EN
    rot   = 1'b0;
`endif

    // Reset state
    do_clear();
    push("rst_out", K_OUT, 16'd0);
    push("rst_pout", K_POUT, 16'd0);
    push("rst_busy", K_BUSY, 16'd0);
    push("rst_done", K_DONE, 16'd0);
    check_all();

    // Clear in the middle of a word: everything zero, no done pulse
    len   = 3'd7;
    pdata = 16'h3CA5;
    load  = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 3; k++) do_step();
    push("mid_busy_pre", K_BUSY, 16'd1);
    check_all();
    do_clear();
    push("mid_out", K_OUT, 16'd0);
    push("mid_busy", K_BUSY, 16'd0);
    push("mid_done", K_DONE, 16'd0);
    push("mid_pout", K_POUT, 16'd0);
    check_all();
    tick();
    push("mid_done_after", K_DONE, 16'd0);
    check_all();

    // Full depth: lane0=A5, lane1=3C
    run_word("w8", 16'h3CA5, 7);

    // Short depth len=2, lane0=0000_0101
    do_clear();
    run_word("w3", 16'h0005, 2);

    // Minimum depth len=0: the single step raises done
    run_word("w1", 16'h0100, 0);

    // Delay-line mode: a single 1 reaches out[0] after exactly 4 steps, done never asserts
    do_clear();
    len = 3'd3;
    for (int k = 1; k <= 6; k++) begin
      in_s = (k == 1) ? 2'b01 : 2'b00;
      do_step();
      push($sformatf("dl_out_s%0d", k), K_OUT, {15'd0, (k == 4)});
      push($sformatf("dl_done_s%0d", k), K_DONE, 16'd0);
      push($sformatf("dl_busy_s%0d", k), K_BUSY, 16'd0);
      check_all();
    end
    in_s = '0;

    // Load and step together: load wins, count starts at 0
    do_clear();
    len   = 3'd7;
    pdata = 16'h1234;
    load  = 1'b1;
    step  = 1'b1;
    tick();
    load = 1'b0;
    step = 1'b0;
    push("ls_pout", K_POUT, 16'h1234);
    push("ls_busy", K_BUSY, 16'd1);
    check_all();
    for (int k = 0; k < 4; k++) begin
      do_step();
      push($sformatf("ls_done_s%0d", k + 1), K_DONE, 16'd0);
      check_all();
    end
    // Reload at cnt=4: previous word abandoned, 8 further steps required
    pdata = 16'hBEEF;
    load  = 1'b1;
    tick();
    load = 1'b0;
    push("rl_pout", K_POUT, 16'hBEEF);
    push("rl_done", K_DONE, 16'd0);
    check_all();
    for (int k = 1; k <= 8; k++) begin
      do_step();
      push($sformatf("rl_done_s%0d", k), K_DONE, {15'd0, (k == 8)});
      push($sformatf("rl_busy_s%0d", k), K_BUSY, {15'd0, (k != 8)});
      check_all();
    end

`ifdef SHIFTREG_MC_ROTATE_EN
    // Rotation within depth 4 restores the loaded nibble after 4 steps
    do_clear();
    rot = 1'b1;
    run_word("rot", 16'h0009, 3);
    push("rot_nib", K_NIB0, 16'h0009);
    check_all();
    rot = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
